// File: rtl/shift_ex_pkg.sv
// Shared types and decode helper for the shift execute stage.
// The SHIFT_EX_FWD_EN macro (see shift_ex_stage) does not affect this package.
package shift_ex_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'd0,
        OP_SRL = 2'd1,
        OP_SRA = 2'd2,
        OP_ILL = 2'd3
    } op_e;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        illegal;
    } ex_entry_t;

    function automatic op_e decode_op(input logic [2:0] funct3, input logic funct7b5);
        op_e op;
        case ({funct3, funct7b5})
            {F3_SLL, 1'b0}: op = OP_SLL;
            {F3_SR,  1'b0}: op = OP_SRL;
            {F3_SR,  1'b1}: op = OP_SRA;
            default:        op = OP_ILL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/shift_ex_core.sv
// Combinational decode and SLL/SRL/SRA datapath; only the low 5 bits of B shift.
module shift_ex_core
    import shift_ex_pkg::*;
#(
    parameter int ILLEGAL_ZERO = 1
) (
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [31:0] op_a,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        illegal
);

    op_e op;

    // Decode the operation and compute the shifted result
    always_comb begin
        op      = decode_op(funct3, funct7b5);
        result  = 32'h0;
        illegal = 1'b0;
        case (op)
            OP_SLL: result = op_a << shamt;
            OP_SRL: result = op_a >> shamt;
            OP_SRA: result = $unsigned($signed(op_a) >>> shamt);
            default: begin
                illegal = 1'b1;
                if (ILLEGAL_ZERO != 0) begin
                    result = 32'h0;
                end else begin
                    result = op_a;
                end
            end
        endcase
    end

endmodule

// File: rtl/shift_ex_stage.sv
// Shift execute stage: decode/shift via shift_ex_core, results queued in a 2-entry FIFO.
// Optional forwarding of operand A from held entries is enabled by SHIFT_EX_FWD_EN.
module shift_ex_stage
    import shift_ex_pkg::*;
#(
    parameter int ILLEGAL_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7b5,
    input  logic        in_is_imm,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_rs1_addr,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    logic [1:0]  count;
    logic        wr_ptr;
    logic        rd_ptr;
    ex_entry_t   mem [2];

    logic        push;
    logic        pop;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] core_result;
    logic        core_illegal;
    ex_entry_t   new_entry;
    ex_entry_t   head;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign op_b      = in_is_imm ? in_imm : in_rs2_data;

`ifdef SHIFT_EX_FWD_EN
    ex_entry_t last_entry;
    logic      unused_hi;
    assign last_entry = mem[~wr_ptr];
    assign unused_hi  = ^op_b[31:5];

    // Forward the newest held result when it targets the source register
    always_comb begin
        if ((count != 2'd0) && (last_entry.rd != 5'd0) && (last_entry.rd == in_rs1_addr)) begin
            op_a = last_entry.result;
        end else begin
            op_a = in_rs1_data;
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^{op_b[31:5], in_rs1_addr};

    // Operand A always comes straight from the register file
    always_comb begin
        op_a = in_rs1_data;
    end
`endif

    shift_ex_core #(.ILLEGAL_ZERO(ILLEGAL_ZERO)) u_core (
        .funct3   (in_funct3),
        .funct7b5 (in_funct7b5),
        .op_a     (op_a),
        .shamt    (op_b[4:0]),
        .result   (core_result),
        .illegal  (core_illegal)
    );

    // Writes to x0 never carry a value, but illegal decode is still flagged
    always_comb begin
        new_entry.rd      = in_rd;
        new_entry.illegal = core_illegal;
        if (in_rd == 5'd0) begin
            new_entry.result = 32'h0;
        end else begin
            new_entry.result = core_result;
        end
    end

    // FIFO storage, pointers and occupancy; flush drops same-cycle push and pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head        = mem[rd_ptr];
    assign out_result  = head.result;
    assign out_rd      = head.rd;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_shift_ex_stage.sv
// Directed self-checking bench for shift_ex_stage; inputs driven and outputs sampled on negedge.
module tb_shift_ex_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic        in_is_imm;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic [4:0]  in_rs1_addr;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int checks   = 0;
    int failures = 0;

    shift_ex_stage #(.ILLEGAL_ZERO(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_is_imm   (in_is_imm),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .in_imm      (in_imm),
        .in_rs1_addr (in_rs1_addr),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [2:0] f3, input logic b5,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        in_valid    = v;
        in_funct3   = f3;
        in_funct7b5 = b5;
        in_is_imm   = 1'b0;
        in_rs1_data = a;
        in_rs2_data = b;
        in_imm      = 32'hDEAD_BEE0;
        in_rs1_addr = 5'd0;
        in_rd       = rd;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_result !== 32'h0) begin failures++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
        checks++; if (out_rd !== 5'd0) begin failures++; $display("FAIL reset_out_rd got=%0d exp=0", out_rd); end
        checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL reset_out_illegal got=%b exp=0", out_illegal); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sra();
        @(negedge clk);
        drive(1'b1, 3'b101, 1'b1, 32'h8000_00F0, 32'd4, 5'd3);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sra_valid got=%b exp=1", out_valid); end
        checks++; if (out_result !== 32'hF800_000F) begin failures++; $display("FAIL sra_result got=%h exp=f800000f", out_result); end
        checks++; if (out_rd !== 5'd3) begin failures++; $display("FAIL sra_rd got=%0d exp=3", out_rd); end
        checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL sra_illegal got=%b exp=0", out_illegal); end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sra_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_imm();
        drive(1'b1, 3'b101, 1'b0, 32'h8000_00F0, 32'h0000_001F, 5'd9);
        in_is_imm = 1'b1;
        in_imm    = 32'hFFFF_FFE4;
        @(negedge clk);
        checks++; if (out_result !== 32'h0800_000F) begin failures++; $display("FAIL srl_imm_result got=%h exp=0800000f", out_result); end
        in_funct3   = 3'b001;
        in_rs1_data = 32'h0000_0001;
        in_rd       = 5'd10;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sll_imm_valid got=%b exp=1", out_valid); end
        checks++; if (out_result !== 32'h0000_0010) begin failures++; $display("FAIL sll_imm_result got=%h exp=00000010", out_result); end
        checks++; if (out_rd !== 5'd10) begin failures++; $display("FAIL sll_imm_rd got=%0d exp=10", out_rd); end
        in_valid  = 1'b0;
        in_is_imm = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        drive(1'b1, 3'b000, 1'b0, 32'h1234_5678, 32'd1, 5'd7);
        @(negedge clk);
        checks++; if (out_result !== 32'h0) begin failures++; $display("FAIL ill_f3_result got=%h exp=0", out_result); end
        checks++; if (out_illegal !== 1'b1) begin failures++; $display("FAIL ill_f3_flag got=%b exp=1", out_illegal); end
        checks++; if (out_rd !== 5'd7) begin failures++; $display("FAIL ill_f3_rd got=%0d exp=7", out_rd); end
        drive(1'b1, 3'b001, 1'b1, 32'h0000_00FF, 32'd2, 5'd8);
        @(negedge clk);
        checks++; if (out_illegal !== 1'b1) begin failures++; $display("FAIL ill_sll_b5_flag got=%b exp=1", out_illegal); end
        checks++; if (out_result !== 32'h0) begin failures++; $display("FAIL ill_sll_b5_result got=%h exp=0", out_result); end
        drive(1'b1, 3'b101, 1'b0, 32'h0000_00F0, 32'd4, 5'd0);
        @(negedge clk);
        checks++; if (out_result !== 32'h0) begin failures++; $display("FAIL rd0_result got=%h exp=0", out_result); end
        checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL rd0_illegal got=%b exp=0", out_illegal); end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 3'b001, 1'b0, 32'h0000_0005, 32'd3, 5'd11);
        @(negedge clk);
        checks++; if (out_result !== 32'h0000_0028) begin failures++; $display("FAIL b2b_first got=%h exp=00000028", out_result); end
        drive(1'b1, 3'b101, 1'b0, 32'hF000_0000, 32'd28, 5'd12);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
        checks++; if (out_result !== 32'h0000_000F) begin failures++; $display("FAIL b2b_second got=%h exp=0000000f", out_result); end
        checks++; if (out_rd !== 5'd12) begin failures++; $display("FAIL b2b_rd got=%0d exp=12", out_rd); end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 3'b001, 1'b0, 32'h0000_0003, 32'd1, 5'd1);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
        drive(1'b1, 3'b101, 1'b0, 32'h0000_0100, 32'd4, 5'd2);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
        checks++; if (out_result !== 32'h0000_0006) begin failures++; $display("FAIL bp_head got=%h exp=00000006", out_result); end
        drive(1'b1, 3'b101, 1'b1, 32'hFFFF_0000, 32'd8, 5'd4);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_third_blocked got=%b exp=0", in_ready); end
        checks++; if (out_result !== 32'h0000_0006 || out_rd !== 5'd1) begin failures++; $display("FAIL bp_hold got=%h/%0d exp=00000006/1", out_result, out_rd); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_return got=%b exp=1", in_ready); end
        checks++; if (out_result !== 32'h0000_0010 || out_rd !== 5'd2) begin failures++; $display("FAIL bp_second got=%h/%0d exp=00000010/2", out_result, out_rd); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 3'b001, 1'b0, 32'd1, 32'd1, 5'd1);
        @(negedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_prefull got=%b exp=0", in_ready); end
        flush    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_push_dropped got=%b exp=0", out_valid); end
        out_ready = 1'b1;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 3'b101, 1'b0, 32'h0000_0F00, 32'd8, 5'd6);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL arst_pre got=%b exp=1", out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_ready got=%b exp=1", in_ready); end
        checks++; if (out_result !== 32'h0 || out_rd !== 5'd0) begin failures++; $display("FAIL arst_data got=%h/%0d exp=0/0", out_result, out_rd); end
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 3'b001, 1'b0, 32'h0000_0001, 32'd31, 5'd13);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h8000_0000) begin failures++; $display("FAIL arst_after got=%b/%h exp=1/80000000", out_valid, out_result); end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

`ifdef SHIFT_EX_FWD_EN
    task automatic test_forward();
        out_ready = 1'b0;
        drive(1'b1, 3'b001, 1'b0, 32'h0000_0010, 32'd4, 5'd5);
        @(negedge clk);
        drive(1'b1, 3'b101, 1'b0, 32'h0000_0000, 32'd4, 5'd6);
        in_rs1_addr = 5'd5;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (out_result !== 32'h0000_0100) begin failures++; $display("FAIL fwd_src got=%h exp=00000100", out_result); end
        @(negedge clk);
        checks++; if (out_result !== 32'h0000_0010) begin failures++; $display("FAIL fwd_result got=%h exp=00000010", out_result); end
        @(negedge clk);
    endtask
`endif

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 5'd0);
        test_reset();
        test_sra();
        test_imm();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
`ifdef SHIFT_EX_FWD_EN
        test_forward();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
